// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
package dmem_pkg;

   localparam int unsigned LANES = 4;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } size_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte-enables/replicated data and load extraction/extension.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  size_t             size,
   input  logic              sign_ext,
   input  logic [1:0]        lane,
   input  logic [31:0]       wd,
   input  logic [31:0]       rword,
   output logic [LANES-1:0]  be,
   output logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   assign rbyte = rword[{lane, 3'b000} +: 8];
   assign rhalf = rword[{lane[1], 4'b0000} +: 16];

   always_comb begin
      be    = '0;
      wdata = wd;
      rdata = '0;
      unique case (size)
         SZ_BYTE: begin
            be    = 4'b0001 << lane;
            wdata = {4{wd[7:0]}};
            rdata = {{24{sign_ext & rbyte[7]}}, rbyte};
         end
         SZ_HALF: begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{wd[15:0]}};
            rdata = {{16{sign_ext & rhalf[15]}}, rhalf};
         end
         SZ_WORD: begin
            be    = 4'b1111;
            rdata = rword;
         end
         SZ_ILL: begin
            be    = '0;
         end
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-port data memory with a three-state request/response handshake,
// sub-word access, alignment and range checking.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH     = 64,
   parameter int unsigned ADDR_W    = 32,
   parameter string       INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [ADDR_W-1:0] a,
   input  logic [31:0]       wd,
   output logic              rsp_valid,
   output logic [31:0]       rd,
   output logic              fault
);

   localparam int unsigned IW = $clog2(DEPTH);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] a_q;
   logic              we_q, sext_q;
   size_t             size_q;
   logic [31:0]       wd_q;
   logic [31:0]       rword_q, rd_q;
   logic              fault_q;
   logic              accept, mis, oor, flt;
   logic [IW-1:0]     idx_in, idx_q;
   logic [LANES-1:0]  be;
   logic [31:0]       wdata, ldata;

   logic [31:0] mem [DEPTH];

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rd        = rd_q;
   assign fault     = fault_q;
   assign accept    = req_valid && req_ready;
   assign idx_in    = a[IW+1:2];
   assign idx_q     = a_q[IW+1:2];
   assign oor       = (a_q >> (IW + 2)) != '0;
   assign flt       = mis | oor;

   always_comb begin
      mis = 1'b1;
      unique case (size_q)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = a_q[0];
         SZ_WORD: mis = |a_q[1:0];
         SZ_ILL:  mis = 1'b1;
      endcase
   end

   dmem_lane_align u_align (
      .size     (size_q),
      .sign_ext (sext_q),
      .lane     (a_q[1:0]),
      .wd       (wd_q),
      .rword    (rword_q),
      .be       (be),
      .wdata    (wdata),
      .rdata    (ldata)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (req_valid) state_d = BUSY;
         BUSY:    state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rd_q    <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == BUSY) begin
            fault_q <= flt;
            rd_q    <= (flt || we_q) ? '0 : ldata;
         end else if (state_q == RESP) begin
            fault_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         a_q    <= a;
         we_q   <= we;
         size_q <= size_t'(size);
         sext_q <= sign_ext;
         wd_q   <= wd;
      end
   end

   // Word is read on the accept edge so BUSY sees it registered, as block RAM would.
   always_ff @(posedge clk) begin
      if (accept) rword_q <= mem[idx_in];
      if (state_q == BUSY && rst_n && we_q && !flt) begin
         for (int i = 0; i < LANES; i++) begin
            if (be[i]) mem[idx_q][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

endmodule
